// File: rtl/codec_init_seq_if.sv
// Write handshake between the init sequencer and i2c_master: request strobe plus data word out,
// one-cycle completion pulse with acknowledge status back.
interface codec_init_seq_if;
  logic        trig;
  logic [15:0] senddata;
  logic        txdone;
  logic        ack_ok;

  modport master (
    output trig,
    output senddata,
    input  txdone,
    input  ack_ok
  );

  modport slave (
    input  trig,
    input  senddata,
    output txdone,
    output ack_ok
  );
endinterface

// File: rtl/codec_init_seq.sv
// Codec register-init sequencer: walks INIT_TABLE in order, writing each word through the
// i2c_master handshake, with per-write NACK/timeout retry and done/error status.
module codec_init_seq #(
  parameter int unsigned              NUM_REGS    = 9,
  parameter logic [NUM_REGS*16-1:0]   INIT_TABLE  = '0,
  parameter int unsigned              PWRUP_CYC   = 50000,
  parameter int unsigned              TRIG_CYC    = 50000,
  parameter int unsigned              GAP_CYC     = 50000,
  parameter int unsigned              TIMEOUT_CYC = 500000,
  parameter int unsigned              MAX_RETRY   = 3,
  parameter bit                       AUTO_START  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  codec_init_seq_if.master i2c,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [7:0]       index_o,
  output logic [3:0]       retries_o
);

  localparam int unsigned MaxA   = (PWRUP_CYC > TRIG_CYC) ? PWRUP_CYC : TRIG_CYC;
  localparam int unsigned MaxB   = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] PwrupLast   = CntW'(PWRUP_CYC - 1);
  localparam logic [CntW-1:0] TrigLast    = CntW'(TRIG_CYC - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      LastIdx     = 8'(NUM_REGS - 1);
  localparam logic [3:0]      RetryMax    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle, StPwrup, StLoad, StTrig, StWait, StGap, StDone, StFail
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            auto_q;
  logic            trig_q;
  logic [15:0]     data_q;
  logic            busy_q, done_q, error_q;
  logic [7:0]      index_q;
  logic [3:0]      retries_q;
  logic            lat_q, lat_ack_q;

  logic [15:0] entry;
  logic        wait_evt, wait_ack, wait_fail;

  always_comb begin
    entry = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (index_q == 8'(k)) entry = INIT_TABLE[16*k +: 16];
    end
  end

  // A txdone caught during TRIG takes precedence over anything arriving live in WAIT.
  assign wait_evt  = lat_q | i2c.txdone;
  assign wait_ack  = lat_q ? lat_ack_q : i2c.ack_ok;
  assign wait_fail = wait_evt ? !wait_ack : (cnt_q == TimeoutLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      auto_q    <= AUTO_START;
      trig_q    <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      index_q   <= '0;
      retries_q <= '0;
      lat_q     <= 1'b0;
      lat_ack_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StFail: begin
          cnt_q <= '0;
          if (start_i || auto_q) begin
            state_q   <= StPwrup;
            auto_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            index_q   <= '0;
            retries_q <= '0;
          end
        end
        StPwrup: begin
          if (cnt_q == PwrupLast) begin
            state_q <= StLoad;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StLoad: begin
          data_q  <= entry;
          lat_q   <= 1'b0;
          trig_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= StTrig;
        end
        StTrig: begin
          if (i2c.txdone && !lat_q) begin
            lat_q     <= 1'b1;
            lat_ack_q <= i2c.ack_ok;
          end
          if (cnt_q == TrigLast) begin
            trig_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StWait;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWait: begin
          if (wait_evt && wait_ack) begin
            cnt_q   <= '0;
            state_q <= StGap;
          end else if (wait_fail) begin
            cnt_q <= '0;
            if (retries_q < RetryMax) begin
              retries_q <= retries_q + 1'b1;
              state_q   <= StLoad;
            end else begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= StFail;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_q <= '0;
            if (index_q == LastIdx) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              index_q   <= index_q + 1'b1;
              retries_q <= '0;
              state_q   <= StLoad;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i2c.trig     = trig_q;
  assign i2c.senddata = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign index_o      = index_q;
  assign retries_o    = retries_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq: scripted i2c_master responder, scoreboard of expected
// write words/retry counts checked at every trig rise, plus timing and status checks.
module tb_codec_init_seq;

  localparam logic [47:0] Table = 48'h1000_0E03_0C00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst0_n, rst1_n, start0, start1;
  logic       busy0, done0, err0, busy1, done1, err1;
  logic [7:0] idx0, idx1;
  logic [3:0] rt0, rt1;

  codec_init_seq_if bus0 ();
  codec_init_seq_if bus1 ();

  codec_init_seq #(
    .NUM_REGS(3), .INIT_TABLE(Table), .PWRUP_CYC(4), .TRIG_CYC(4), .GAP_CYC(4),
    .TIMEOUT_CYC(20), .MAX_RETRY(2), .AUTO_START(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst0_n), .start_i(start0), .i2c(bus0), .busy_o(busy0),
    .done_o(done0), .error_o(err0), .index_o(idx0), .retries_o(rt0)
  );

  codec_init_seq #(
    .NUM_REGS(3), .INIT_TABLE(Table), .PWRUP_CYC(4), .TRIG_CYC(4), .GAP_CYC(4),
    .TIMEOUT_CYC(20), .MAX_RETRY(2), .AUTO_START(1'b0)
  ) u_dut_ns (
    .clk_i(clk), .rst_ni(rst1_n), .start_i(start1), .i2c(bus1), .busy_o(busy1),
    .done_o(done1), .error_o(err1), .index_o(idx1), .retries_o(rt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  rt;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input logic [15:0] d, input logic [3:0] r);
    exp_q.push_back('{data: d, rt: r});
  endtask

  task automatic push_seq();
    push(16'h0C00, 4'd0);
    push(16'h0E03, 4'd0);
    push(16'h1000, 4'd0);
  endtask

  // Responder modes for instance 0, keyed on the entry index seen at trig rise.
  int nack_ent = -1, silent_ent = -1, early_ent = -1;

  initial begin
    logic ack;
    bus0.txdone = 1'b0;
    bus0.ack_ok = 1'b0;
    forever begin
      @(posedge bus0.trig);
      #1;
      if (int'(idx0) == silent_ent) begin
        // no response at all
      end else if (int'(idx0) == early_ent) begin
        @(posedge clk); #1;
        bus0.txdone = 1'b1; bus0.ack_ok = 1'b1;
        @(posedge clk); #1;
        bus0.txdone = 1'b0; bus0.ack_ok = 1'b0;
      end else begin
        ack = !(int'(idx0) == nack_ent && rt0 == 4'd0);
        @(negedge bus0.trig); #1;
        @(posedge clk);
        @(posedge clk); #1;
        bus0.txdone = 1'b1; bus0.ack_ok = ack;
        @(posedge clk); #1;
        bus0.txdone = 1'b0; bus0.ack_ok = 1'b0;
      end
    end
  end

  initial begin
    bus1.txdone = 1'b0;
    bus1.ack_ok = 1'b0;
    forever begin
      @(negedge bus1.trig); #1;
      @(posedge clk);
      @(posedge clk); #1;
      bus1.txdone = 1'b1; bus1.ack_ok = 1'b1;
      @(posedge clk); #1;
      bus1.txdone = 1'b0; bus1.ack_ok = 1'b0;
    end
  end

  // Scoreboard pop at every trig rise; pulse width checked on each non-reset fall.
  logic mon_prev = 1'b0;
  int   mon_width = 0;
  always begin
    exp_t e;
    @(posedge clk); #1;
    if (bus0.trig && !mon_prev) begin
      mon_width = 1;
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("senddata", 32'(bus0.senddata), 32'(e.data));
        check("retries_at_trig", 32'(rt0), 32'(e.rt));
      end
    end else if (bus0.trig) begin
      mon_width++;
    end else if (mon_prev && rst0_n) begin
      check("trig_width", 32'(mon_width), 32'd4);
    end
    mon_prev = bus0.trig;
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return done0;
      1:       return err0;
      2:       return bus0.trig;
      3:       return !bus0.trig;
      4:       return busy0;
      5:       return done1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string tag, output int at);
    int n = 0;
    while (!sig(sel) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(sig(sel)), 32'd1);
    at = cyc;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, t1, tf, tr, last_fall, n;
    logic tprev;
    rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    check("rst_trig", 32'(bus0.trig), 32'd0);
    check("rst_senddata", 32'(bus0.senddata), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_error", 32'(err0), 32'd0);
    check("rst_index", 32'(idx0), 32'd0);
    check("rst_retries", 32'(rt0), 32'd0);

    // AUTO_START=0 instance: idles until start, ignores start while busy.
    rst1_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ns_idle_busy", 32'(busy1), 32'd0);
    check("ns_idle_done", 32'(done1), 32'd0);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    t0 = cyc;
    check("ns_started", 32'(busy1), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_for(5, 100, "ns_done_wait", t1);
    check("ns_seq_len", 32'(t1 - t0), 32'd40);
    check("ns_error", 32'(err1), 32'd0);

    // Plain sequence after reset release with auto-start.
    push_seq();
    rst0_n = 1'b1;
    wait_for(4, 10, "auto_busy_wait", t0);
    wait_for(0, 200, "seq_done_wait", t1);
    check("seq_len", 32'(t1 - t0), 32'd40);
    check("seq_busy_end", 32'(busy0), 32'd0);
    check("seq_error", 32'(err0), 32'd0);
    check("seq_trig_end", 32'(bus0.trig), 32'd0);
    check("seq_sb_drained", 32'(exp_q.size()), 32'd0);

    // NACK on first attempt of entry 1.
    nack_ent = 1;
    push(16'h0C00, 4'd0);
    push(16'h0E03, 4'd0);
    push(16'h0E03, 4'd1);
    push(16'h1000, 4'd0);
    pulse_start0();
    check("restart_done_clr", 32'(done0), 32'd0);
    check("restart_busy", 32'(busy0), 32'd1);
    wait_for(0, 300, "nack_done_wait", t1);
    check("nack_error", 32'(err0), 32'd0);
    check("nack_index", 32'(idx0), 32'd2);
    check("nack_sb_drained", 32'(exp_q.size()), 32'd0);
    nack_ent = -1;

    // ACK during TRIG on entry 0: single WAIT cycle, no retry.
    early_ent = 0;
    push_seq();
    pulse_start0();
    wait_for(2, 20, "early_trig_rise", t0);
    wait_for(3, 20, "early_trig_fall", tf);
    wait_for(2, 20, "early_next_rise", tr);
    check("early_fall_to_rise", 32'(tr - tf), 32'd6);
    wait_for(0, 200, "early_done_wait", t1);
    check("early_sb_drained", 32'(exp_q.size()), 32'd0);
    early_ent = -1;

    // No response on entry 2: three timed-out attempts, then FAIL.
    silent_ent = 2;
    push_seq();
    push(16'h1000, 4'd1);
    push(16'h1000, 4'd2);
    pulse_start0();
    tprev = bus0.trig;
    last_fall = cyc;
    n = 0;
    while (!err0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (!bus0.trig && tprev) last_fall = cyc;
      tprev = bus0.trig;
    end
    check("fail_error", 32'(err0), 32'd1);
    check("fail_timeout_len", 32'(cyc - last_fall), 32'd20);
    check("fail_index", 32'(idx0), 32'd2);
    check("fail_retries", 32'(rt0), 32'd2);
    check("fail_trig", 32'(bus0.trig), 32'd0);
    check("fail_busy", 32'(busy0), 32'd0);
    check("fail_done", 32'(done0), 32'd0);
    check("fail_sb_drained", 32'(exp_q.size()), 32'd0);
    silent_ent = -1;

    // start in FAIL reruns from entry 0 with error cleared.
    push_seq();
    pulse_start0();
    check("rerun_error_clr", 32'(err0), 32'd0);
    check("rerun_busy", 32'(busy0), 32'd1);
    check("rerun_index", 32'(idx0), 32'd0);
    wait_for(0, 200, "rerun_done_wait", t1);
    check("rerun_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset during the second TRIG, then auto-restart from entry 0.
    push(16'h0C00, 4'd0);
    push(16'h0E03, 4'd0);
    pulse_start0();
    wait_for(2, 20, "rst_trig1_rise", t0);
    wait_for(3, 20, "rst_trig1_fall", tf);
    wait_for(2, 20, "rst_trig2_rise", tr);
    @(posedge clk);
    #3;
    rst0_n = 1'b0;
    #1;
    check("midrst_trig", 32'(bus0.trig), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_senddata", 32'(bus0.senddata), 32'd0);
    check("midrst_sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    push_seq();
    rst0_n = 1'b1;
    wait_for(4, 10, "midrst_auto_busy", t0);
    wait_for(0, 200, "midrst_done_wait", t1);
    check("midrst_seq_len", 32'(t1 - t0), 32'd40);
    check("midrst_sb_drained2", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
